zint_multi: RTL and testbench
=============================

Name: zint_multi

Overview:
- Parametrised successor to the single-source frame interrupt generator.
- Collects NSRC interrupt requests (frame, line, DMA-end, SD-done, ...) into pending latches, applies an enable mask and fixed priority, then drives Z80 /INT for a programmable number of Z80 clocks.
- Supplies an IM2 vector on the data bus during INTACK.
- Sits between the video sync/fetch and peripheral blocks (request strobes) and the Z80 bus mux (vector data).

Parameters:
- NSRC, 4: number of interrupt sources, 1..2^IW.
- IW, 2: width of the source index.
- PW, 6: width of the INT pulse-length counter.
- VEC_BASE, 8'hF0: IM2 vector for source 0. Source i returns VEC_BASE + 2*i, 8-bit wrap.

Ports:
- fclk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- zpos  in  1  one-fclk strobe marking a Z80 clock rising edge.
- src_stb  in  NSRC  one-fclk request pulse per source.
- int_ena  in  NSRC  per-source enable mask (1 = enabled).
- pend_clr  in  NSRC  software clear of pending bits, one-fclk pulse.
- int_len  in  PW  /INT length in Z80 clocks; 0 is treated as 1.
- iorq_n  in  1  Z80 /IORQ, already synchronised to fclk.
- m1_n  in  1  Z80 /M1, already synchronised to fclk.
- int_n  out  1  Z80 /INT, active low.
- vec_dout  out  8  IM2 vector byte.
- vec_ena  out  1  drive vec_dout onto the Z80 data bus.
- pending  out  NSRC  pending latch state.
- cur_src  out  IW  index of the source being signalled or acknowledged.
- miss_stb  out  1  one-fclk pulse when an INT window expires unacknowledged.

Behaviour:

Reset (async, rst_n=0):
- int_n=1, vec_ena=0, vec_dout=8'h00, pending=0, cur_src=0, miss_stb=0, counter=0, state=IDLE.
- Reset applies immediately, including mid-pulse or mid-ACK.

Pending latches:
- pending[i] sets on src_stb[i].
- pending[i] clears on pend_clr[i], on acknowledge of i, or on miss of i.
- Set wins over any clear in the same cycle.
- Masked sources stay pending; they become eligible as soon as int_ena[i] rises.

Priority:
- The lowest index among (pending & int_ena) wins.
- The winner is captured into cur_src at assertion and frozen until the cycle returns to IDLE. A higher-priority source arriving later waits.

State machine (fclk domain):
- IDLE:
  - if zpos and |(pending & int_ena): go to ASSERT; capture cur_src; counter = max(int_len,1); int_n=0 from the next fclk.
- ASSERT:
  - if iorq_n=0 and m1_n=0 (INTACK): go to ACK; int_n=1 next cycle; pending[cur_src] cleared; vec_dout = VEC_BASE + {cur_src,1'b0}; vec_ena=1.
  - else on each zpos the counter decrements. On zpos with counter==1: go to IDLE; int_n=1; pending[cur_src] cleared; miss_stb=1 for one cycle.
  - INTACK detection has priority over expiry in the same cycle.
- ACK:
  - vec_ena and vec_dout held while iorq_n=0.
  - on iorq_n=1: vec_ena=0, go to IDLE. vec_dout keeps its value (don't-care when not enabled).
- A new assertion may start on the first zpos after returning to IDLE; there is no minimum gap.

Timing and width rules:
- Latency from src_stb to int_n low: from 1 fclk after the next zpos (if zpos coincides with src_stb, the following zpos counts).
- int_ena and pend_clr changes during ASSERT do not abort the pulse.
- pend_clr of cur_src during ASSERT still lets ACK or miss complete normally.
- Vector arithmetic is modulo 256.
- int_len is sampled only on IDLE→ASSERT.

Test Plan:
- Single source: src_stb[0], int_ena=4'b0001, int_len=32 -> int_n low for 32 zpos strobes, miss_stb pulses once, pending[0]=0 afterwards.
- Acknowledge: src_stb[2] then INTACK (m1_n=0, iorq_n=0) at the 5th zpos -> int_n=1 next fclk, vec_ena=1, vec_dout=8'hF4, pending[2]=0; iorq_n=1 -> vec_ena=0.
- Priority and freeze: src_stb[3] and src_stb[1] in the same cycle -> cur_src=1, vector 8'hF2; src_stb[0] during ASSERT -> cur_src stays 1, source 0 is served next, then source 3.
- Masking: src_stb[1] with int_ena[1]=0 -> no INT, pending[1]=1; raise int_ena[1] -> INT at the next zpos.
- Same-cycle set and clear: src_stb[0] with pend_clr[0] -> pending[0]=1. int_len=0 -> INT lasts exactly 1 zpos.
- Reset mid-ACK: rst_n=0 while vec_ena=1 -> int_n=1, vec_ena=0, pending=0 immediately, without waiting for an fclk edge.

Source files
------------

// File: rtl/zint_multi.sv
// Multi-source Z80 interrupt controller: pending latches, enable mask, fixed
// priority, programmable /INT width and IM2 vector supply during INTACK.
module zint_multi #(
  parameter int unsigned NSRC     = 4,
  parameter int unsigned IW       = 2,
  parameter int unsigned PW       = 6,
  parameter logic [7:0]  VEC_BASE = 8'hF0
) (
  input  logic            fclk,
  input  logic            rst_n,
  input  logic            zpos,
  input  logic [NSRC-1:0] src_stb,
  input  logic [NSRC-1:0] int_ena,
  input  logic [NSRC-1:0] pend_clr,
  input  logic [PW-1:0]   int_len,
  input  logic            iorq_n,
  input  logic            m1_n,
  output logic            int_n,
  output logic [7:0]      vec_dout,
  output logic            vec_ena,
  output logic [NSRC-1:0] pending,
  output logic [IW-1:0]   cur_src,
  output logic            miss_stb
);

  typedef enum logic [1:0] {IDLE, ASSERT, ACK} state_e;

  state_e          state_q, state_d;
  logic            int_n_q, int_n_d;
  logic [7:0]      vec_dout_q, vec_dout_d;
  logic            vec_ena_q, vec_ena_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [IW-1:0]   cur_src_q, cur_src_d;
  logic            miss_stb_q, miss_stb_d;
  logic [PW-1:0]   cnt_q, cnt_d;

  logic [NSRC-1:0] elig_c;
  logic [IW-1:0]   win_c;
  logic            clr_src_c;

  // Lowest eligible index wins
  always_comb begin
    elig_c = pending_q & int_ena;
    win_c  = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (elig_c[i]) win_c = IW'(i);
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      int_n_q    <= 1'b1;
      vec_dout_q <= 8'h00;
      vec_ena_q  <= 1'b0;
      pending_q  <= '0;
      cur_src_q  <= '0;
      miss_stb_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      int_n_q    <= int_n_d;
      vec_dout_q <= vec_dout_d;
      vec_ena_q  <= vec_ena_d;
      pending_q  <= pending_d;
      cur_src_q  <= cur_src_d;
      miss_stb_q <= miss_stb_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    int_n_d    = int_n_q;
    vec_dout_d = vec_dout_q;
    vec_ena_d  = vec_ena_q;
    cur_src_d  = cur_src_q;
    miss_stb_d = 1'b0;
    cnt_d      = cnt_q;
    clr_src_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (zpos && (|elig_c)) begin
          state_d   = ASSERT;
          cur_src_d = win_c;
          cnt_d     = (int_len == '0) ? PW'(1) : int_len;
          int_n_d   = 1'b0;
        end
      end
      ASSERT: begin
        // INTACK takes precedence over window expiry
        if (!iorq_n && !m1_n) begin
          state_d    = ACK;
          int_n_d    = 1'b1;
          clr_src_c  = 1'b1;
          vec_dout_d = VEC_BASE + 8'({cur_src_q, 1'b0});
          vec_ena_d  = 1'b1;
        end else if (zpos) begin
          if (cnt_q == PW'(1)) begin
            state_d    = IDLE;
            int_n_d    = 1'b1;
            clr_src_c  = 1'b1;
            miss_stb_d = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q - PW'(1);
          end
        end
      end
      ACK: begin
        if (iorq_n) begin
          vec_ena_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // New requests override any clear in the same cycle
    pending_d = pending_q & ~pend_clr;
    if (clr_src_c) pending_d = pending_d & ~(NSRC'(1) << cur_src_q);
    pending_d = pending_d | src_stb;
  end

  assign int_n    = int_n_q;
  assign vec_dout = vec_dout_q;
  assign vec_ena  = vec_ena_q;
  assign pending  = pending_q;
  assign cur_src  = cur_src_q;
  assign miss_stb = miss_stb_q;

endmodule

// File: tb/tb_zint_multi.sv
// Directed bench for zint_multi with hand-computed expectations.
module tb_zint_multi;

  logic       fclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       zpos = 1'b0;
  logic [3:0] src_stb = '0;
  logic [3:0] int_ena = '0;
  logic [3:0] pend_clr = '0;
  logic [5:0] int_len = '0;
  logic       iorq_n = 1'b1;
  logic       m1_n = 1'b1;
  logic       int_n;
  logic [7:0] vec_dout;
  logic       vec_ena;
  logic [3:0] pending;
  logic [1:0] cur_src;
  logic       miss_stb;

  int n_tests = 0;
  int n_fail  = 0;

  zint_multi dut (
    .fclk(fclk), .rst_n(rst_n), .zpos(zpos), .src_stb(src_stb),
    .int_ena(int_ena), .pend_clr(pend_clr), .int_len(int_len),
    .iorq_n(iorq_n), .m1_n(m1_n), .int_n(int_n), .vec_dout(vec_dout),
    .vec_ena(vec_ena), .pending(pending), .cur_src(cur_src), .miss_stb(miss_stb)
  );

  always #5 fclk = ~fclk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge fclk);
    #1;
  endtask

  task automatic zp();
    zpos = 1'b1;
    cyc();
    zpos = 1'b0;
  endtask

  task automatic stb(input logic [3:0] s);
    src_stb = s;
    cyc();
    src_stb = '0;
  endtask

  // INTACK for one fclk, then release and return to IDLE
  task automatic ack(input string tag, input logic [1:0] src, input logic [7:0] vec);
    m1_n = 1'b0; iorq_n = 1'b0;
    cyc();
    check({tag, "_int_n"}, 32'(int_n), 32'h1);
    check({tag, "_vec_ena"}, 32'(vec_ena), 32'h1);
    check({tag, "_vec"}, 32'(vec_dout), 32'(vec));
    check({tag, "_src"}, 32'(cur_src), 32'(src));
    m1_n = 1'b1; iorq_n = 1'b1;
    cyc();
    check({tag, "_vec_off"}, 32'(vec_ena), 32'h0);
  endtask

  initial begin
    int cnt;
    #1 rst_n = 1'b0;
    cyc(); cyc();
    check("rst_int_n", 32'(int_n), 32'h1);
    check("rst_vec_ena", 32'(vec_ena), 32'h0);
    check("rst_vec", 32'(vec_dout), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_cur_src", 32'(cur_src), 32'h0);
    check("rst_miss", 32'(miss_stb), 32'h0);
    rst_n = 1'b1;
    cyc();

    // Single source expiring after 32 zpos
    int_ena = 4'b0001; int_len = 6'd32;
    stb(4'b0001);
    check("s1_pend", 32'(pending), 32'h1);
    zp();
    check("s1_low", 32'(int_n), 32'h0);
    cnt = 0;
    while (int_n == 1'b0 && cnt < 100) begin
      zp();
      cnt++;
    end
    check("s1_len", 32'(cnt), 32'd32);
    check("s1_miss", 32'(miss_stb), 32'h1);
    check("s1_pend_clr", 32'(pending), 32'h0);
    cyc();
    check("s1_miss_once", 32'(miss_stb), 32'h0);

    // Acknowledge at the 5th zpos
    int_ena = 4'b1111; int_len = 6'd8;
    stb(4'b0100);
    zp();
    check("a_low", 32'(int_n), 32'h0);
    check("a_src", 32'(cur_src), 32'h2);
    for (int i = 0; i < 4; i++) zp();
    check("a_still_low", 32'(int_n), 32'h0);
    zpos = 1'b1; m1_n = 1'b0; iorq_n = 1'b0;
    cyc();
    zpos = 1'b0;
    check("a_int_n", 32'(int_n), 32'h1);
    check("a_vec_ena", 32'(vec_ena), 32'h1);
    check("a_vec", 32'(vec_dout), 32'hF4);
    check("a_pend", 32'(pending), 32'h0);
    check("a_no_miss", 32'(miss_stb), 32'h0);
    m1_n = 1'b1;
    cyc();
    check("a_hold", 32'(vec_ena), 32'h1);
    iorq_n = 1'b1;
    cyc();
    check("a_release", 32'(vec_ena), 32'h0);
    check("a_vec_keep", 32'(vec_dout), 32'hF4);

    // Priority and freeze
    stb(4'b1010);
    zp();
    check("p_src1", 32'(cur_src), 32'h1);
    stb(4'b0001);
    check("p_pend", 32'(pending), 32'hB);
    zp();
    check("p_frozen", 32'(cur_src), 32'h1);
    ack("p1", 2'd1, 8'hF2);
    check("p_pend2", 32'(pending), 32'h9);
    zp();
    check("p0_low", 32'(int_n), 32'h0);
    ack("p0", 2'd0, 8'hF0);
    zp();
    ack("p3", 2'd3, 8'hF6);
    check("p_pend_empty", 32'(pending), 32'h0);

    // Masked source waits until enabled
    int_ena = 4'b1101;
    stb(4'b0010);
    zp();
    check("m_no_int", 32'(int_n), 32'h1);
    check("m_pend", 32'(pending), 32'h2);
    int_ena = 4'b1111;
    zp();
    check("m_int", 32'(int_n), 32'h0);
    ack("m", 2'd1, 8'hF2);

    // Same-cycle set and clear; then plain clear
    int_ena = 4'b0000;
    stb(4'b0001);
    src_stb = 4'b0001; pend_clr = 4'b0001;
    cyc();
    src_stb = '0;
    check("sc_set_wins", 32'(pending), 32'h1);
    cyc();
    pend_clr = 4'b0000;
    check("sc_clear", 32'(pending), 32'h0);

    // zpos coinciding with the strobe does not count; int_len=0 gives 1 zpos
    int_ena = 4'b1111; int_len = 6'd0;
    zpos = 1'b1; src_stb = 4'b0100;
    cyc();
    zpos = 1'b0; src_stb = '0;
    check("lat_no_int", 32'(int_n), 32'h1);
    zp();
    check("l0_low", 32'(int_n), 32'h0);
    zp();
    check("l0_end", 32'(int_n), 32'h1);
    check("l0_miss", 32'(miss_stb), 32'h1);

    // Asynchronous reset during ACK
    int_len = 6'd8;
    stb(4'b0100);
    zp();
    stb(4'b1000);
    m1_n = 1'b0; iorq_n = 1'b0;
    cyc();
    check("r_vec_ena", 32'(vec_ena), 32'h1);
    check("r_pend", 32'(pending), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    check("r_int_n", 32'(int_n), 32'h1);
    check("r_vec_off", 32'(vec_ena), 32'h0);
    check("r_pend_clr", 32'(pending), 32'h0);
    m1_n = 1'b1; iorq_n = 1'b1;
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
